// File: rtl/store_check_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : store_check_monitor
// Purpose  : Store-trace checker placed on the data-memory write port of a
//            RISC-V pipeline.  A table of expected (address, data) stores is
//            programmed while idle.  After start, every committed store is
//            compared against the table, and the monitor settles in PASS
//            (all valid entries seen with correct data), FAIL (an expected
//            address was written with wrong data) or TIMEOUT.
// Ports    : clk, rst                  - clock, synchronous active-high reset
//            cfg_we/cfg_idx/cfg_addr/
//            cfg_data                  - table programming (IDLE only)
//            start                     - begin checking (IDLE only)
//            memwrite/dataadr/writedata- observed store bus
//            done/pass/fail/timeout    - registered verdict flags
//            hit_count                 - distinct entries matched so far
//            fail_addr/fail_data       - offending store on FAIL
// Revision : 1.0 - initial release
// ============================================================================
module store_check_monitor #(
    parameter int NUM_CHECKS     = 4,
    parameter int TIMEOUT_CYCLES = 100,
    parameter int CNT_W          = 16,
    localparam int c_IDX_W = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1,
    localparam int c_HC_W  = $clog2(NUM_CHECKS + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_we,
    input  logic [c_IDX_W-1:0]  cfg_idx,
    input  logic [31:0]         cfg_addr,
    input  logic [31:0]         cfg_data,
    input  logic                start,
    input  logic                memwrite,
    input  logic [31:0]         dataadr,
    input  logic [31:0]         writedata,
    output logic                done,
    output logic                pass,
    output logic                fail,
    output logic                timeout,
    output logic [c_HC_W-1:0]   hit_count,
    output logic [31:0]         fail_addr,
    output logic [31:0]         fail_data
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RUN     = 3'd1,
        S_PASS    = 3'd2,
        S_FAIL    = 3'd3,
        S_TIMEOUT = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;

    logic [31:0]            r_exp_addr [NUM_CHECKS];
    logic [31:0]            r_exp_data [NUM_CHECKS];
    logic [NUM_CHECKS-1:0]  r_valid;
    logic [NUM_CHECKS-1:0]  r_hit;
    logic [CNT_W-1:0]       r_timer;
    logic [c_HC_W-1:0]      r_hit_count;
    logic [31:0]            r_fail_addr;
    logic [31:0]            r_fail_data;

    logic                   w_match;
    logic [c_IDX_W-1:0]     w_match_idx;
    logic                   w_store_ok;
    logic                   w_store_bad;
    logic                   w_new_hit;
    logic [NUM_CHECKS-1:0]  w_hit_after;
    logic                   w_all_hit;
    logic                   w_any_valid;
    logic [CNT_W-1:0]       w_timer_next;
    logic                   w_timer_expire;

    // Parallel address compare. Scanning from the top index down lets the
    // lowest matching index overwrite the others, so duplicates resolve to
    // the lowest entry.
    always_comb begin
        w_match     = 1'b0;
        w_match_idx = '0;
        for (int i = NUM_CHECKS - 1; i >= 0; i--) begin
            if (memwrite && r_valid[i] && (r_exp_addr[i] == dataadr)) begin
                w_match     = 1'b1;
                w_match_idx = c_IDX_W'(i);
            end
        end
    end

    assign w_store_ok  = w_match &&  (r_exp_data[w_match_idx] == writedata);
    assign w_store_bad = w_match && !(r_exp_data[w_match_idx] == writedata);
    assign w_new_hit   = w_store_ok && !r_hit[w_match_idx];

    // Hit vector as it will look after this edge, so completion can be
    // declared on the same edge that samples the final store.
    always_comb begin
        w_hit_after = r_hit;
        for (int i = 0; i < NUM_CHECKS; i++) begin
            if (w_store_ok && (w_match_idx == c_IDX_W'(i))) begin
                w_hit_after[i] = 1'b1;
            end
        end
    end

    assign w_all_hit      = &(~r_valid | w_hit_after);
    assign w_any_valid    = |r_valid;
    assign w_timer_next   = r_timer + CNT_W'(1);
    assign w_timer_expire = (w_timer_next == CNT_W'(TIMEOUT_CYCLES));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic; verdict priority is FAIL, then PASS, then TIMEOUT
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    // An empty table has nothing to wait for.
                    w_state_next = w_any_valid ? S_RUN : S_PASS;
                end
            end
            S_RUN: begin
                if (w_store_bad) begin
                    w_state_next = S_FAIL;
                end else if (w_all_hit) begin
                    w_state_next = S_PASS;
                end else if (w_timer_expire) begin
                    w_state_next = S_TIMEOUT;
                end
            end
            S_PASS, S_FAIL, S_TIMEOUT: begin
                w_state_next = r_state;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Table, timer and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CHECKS; i++) begin
                r_exp_addr[i] <= '0;
                r_exp_data[i] <= '0;
            end
            r_valid     <= '0;
            r_hit       <= '0;
            r_timer     <= '0;
            r_hit_count <= '0;
            r_fail_addr <= '0;
            r_fail_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_hit       <= '0;
                        r_timer     <= '0;
                        r_hit_count <= '0;
                    end
                    // Out-of-range indices match no entry and are dropped.
                    if (cfg_we) begin
                        for (int i = 0; i < NUM_CHECKS; i++) begin
                            if (cfg_idx == c_IDX_W'(i)) begin
                                r_exp_addr[i] <= cfg_addr;
                                r_exp_data[i] <= cfg_data;
                                r_valid[i]    <= 1'b1;
                                r_hit[i]      <= 1'b0;
                            end
                        end
                    end
                end
                S_RUN: begin
                    r_timer <= w_timer_next;
                    if (w_store_bad) begin
                        r_fail_addr <= dataadr;
                        r_fail_data <= writedata;
                    end else if (w_store_ok) begin
                        r_hit <= w_hit_after;
                        if (w_new_hit) begin
                            r_hit_count <= r_hit_count + c_HC_W'(1);
                        end
                    end
                end
                default: begin
                    // Terminal states freeze everything until reset.
                end
            endcase
        end
    end

    assign pass      = (r_state == S_PASS);
    assign fail      = (r_state == S_FAIL);
    assign timeout   = (r_state == S_TIMEOUT);
    assign done      = pass | fail | timeout;
    assign hit_count = r_hit_count;
    assign fail_addr = r_fail_addr;
    assign fail_data = r_fail_data;

endmodule
`default_nettype wire

// File: tb/tb_store_check_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_store_check_monitor
// Purpose  : Self-checking bench for store_check_monitor.  Directed scenarios
//            followed by randomized episodes, all compared every cycle
//            against a behavioural table model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_store_check_monitor;

    localparam int NUM     = 4;
    localparam int TIMEOUT = 10;

    localparam int c_st_idle    = 0;
    localparam int c_st_run     = 1;
    localparam int c_st_pass    = 2;
    localparam int c_st_fail    = 3;
    localparam int c_st_timeout = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_idx = '0;
    logic [31:0] cfg_addr = '0;
    logic [31:0] cfg_data = '0;
    logic        start = 1'b0;
    logic        memwrite = 1'b0;
    logic [31:0] dataadr = '0;
    logic [31:0] writedata = '0;
    logic        done;
    logic        pass;
    logic        fail;
    logic        timeout;
    logic [2:0]  hit_count;
    logic [31:0] fail_addr;
    logic [31:0] fail_data;

    int n_cmp = 0;
    int n_err = 0;

    store_check_monitor #(
        .NUM_CHECKS     (NUM),
        .TIMEOUT_CYCLES (TIMEOUT),
        .CNT_W          (16)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_idx   (cfg_idx),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .start     (start),
        .memwrite  (memwrite),
        .dataadr   (dataadr),
        .writedata (writedata),
        .done      (done),
        .pass      (pass),
        .fail      (fail),
        .timeout   (timeout),
        .hit_count (hit_count),
        .fail_addr (fail_addr),
        .fail_data (fail_data)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: a table of expectations and a verdict
    // ------------------------------------------------------------------
    int          m_state = c_st_idle;
    int          m_run_cycles = 0;
    logic [31:0] m_addr [NUM];
    logic [31:0] m_data [NUM];
    bit          m_valid [NUM];
    bit          m_hit [NUM];
    logic [31:0] m_fail_addr = '0;
    logic [31:0] m_fail_data = '0;

    task automatic model_edge();
        int  win;
        bit  any;
        bit  all;
        if (rst) begin
            m_state = c_st_idle;
            m_run_cycles = 0;
            for (int i = 0; i < NUM; i++) begin
                m_valid[i] = 0;
                m_hit[i]   = 0;
                m_addr[i]  = '0;
                m_data[i]  = '0;
            end
            m_fail_addr = '0;
            m_fail_data = '0;
            return;
        end
        if (m_state == c_st_idle) begin
            if (start) begin
                any = 0;
                for (int i = 0; i < NUM; i++) begin
                    any |= m_valid[i];
                    m_hit[i] = 0;
                end
                m_run_cycles = 0;
                m_state = any ? c_st_run : c_st_pass;
            end else if (cfg_we && int'(cfg_idx) < NUM) begin
                m_addr[cfg_idx]  = cfg_addr;
                m_data[cfg_idx]  = cfg_data;
                m_valid[cfg_idx] = 1;
                m_hit[cfg_idx]   = 0;
            end
        end else if (m_state == c_st_run) begin
            m_run_cycles++;
            win = -1;
            if (memwrite) begin
                for (int i = 0; i < NUM; i++) begin
                    if (win < 0 && m_valid[i] && m_addr[i] == dataadr) win = i;
                end
            end
            if (win >= 0 && m_data[win] != writedata) begin
                m_state = c_st_fail;
                m_fail_addr = dataadr;
                m_fail_data = writedata;
            end else begin
                if (win >= 0) m_hit[win] = 1;
                all = 1;
                for (int i = 0; i < NUM; i++) begin
                    if (m_valid[i] && !m_hit[i]) all = 0;
                end
                if (all) m_state = c_st_pass;
                else if (m_run_cycles >= TIMEOUT) m_state = c_st_timeout;
            end
        end
    endtask

    function automatic int model_hits();
        int n = 0;
        for (int i = 0; i < NUM; i++) begin
            if (m_valid[i] && m_hit[i]) n++;
        end
        return n;
    endfunction

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_all();
        bit e_pass, e_fail, e_to;
        e_pass = (m_state == c_st_pass);
        e_fail = (m_state == c_st_fail);
        e_to   = (m_state == c_st_timeout);
        check_val("pass",      32'(pass),      32'(e_pass));
        check_val("fail",      32'(fail),      32'(e_fail));
        check_val("timeout",   32'(timeout),   32'(e_to));
        check_val("done",      32'(done),      32'(e_pass | e_fail | e_to));
        check_val("hit_count", 32'(hit_count), 32'(model_hits()));
        check_val("fail_addr", fail_addr,      m_fail_addr);
        check_val("fail_data", fail_data,      m_fail_data);
    endtask

    // One clock: model follows the edge, DUT outputs sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic program_entry(input int idx, input logic [31:0] a, input logic [31:0] d);
        cfg_we   = 1'b1;
        cfg_idx  = 2'(idx);
        cfg_addr = a;
        cfg_data = d;
        tick();
        cfg_we   = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d);
        memwrite  = 1'b1;
        dataadr   = a;
        writedata = d;
        tick();
        memwrite  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic program_default();
        program_entry(0, 32'd600, 32'hABCD_E000);
        program_entry(1, 32'd604, 32'd4100);
    endtask

    function automatic logic [31:0] good_data(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] pool_addr();
        return 32'h200 + 32'(4 * $urandom_range(0, 5));
    endfunction

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        logic [31:0] a;
        logic [31:0] d;
        int          r;

        do_reset();
        do_reset();
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_hits", 32'(hit_count), 32'd0);

        // Two good stores complete the table
        program_default();
        do_start();
        do_store(32'd600, 32'hABCD_E000);
        check_val("s1_hits1", 32'(hit_count), 32'd1);
        check_val("s1_nopass", 32'(pass), 32'd0);
        do_store(32'd604, 32'h0000_1004);
        check_val("s1_hits2", 32'(hit_count), 32'd2);
        check_val("s1_pass", 32'(pass), 32'd1);
        check_val("s1_done", 32'(done), 32'd1);
        idle(2);

        // Wrong data on an expected address, later store has no effect
        do_reset();
        program_default();
        do_start();
        do_store(32'd604, 32'h0000_1000);
        check_val("s2_fail", 32'(fail), 32'd1);
        check_val("s2_faddr", fail_addr, 32'd604);
        check_val("s2_fdata", fail_data, 32'h0000_1000);
        check_val("s2_hits", 32'(hit_count), 32'd0);
        do_store(32'd604, 32'd4100);
        check_val("s2_hold_fail", 32'(fail), 32'd1);
        check_val("s2_hold_fdata", fail_data, 32'h0000_1000);

        // No stores: timeout exactly TIMEOUT cycles after entering RUN
        do_reset();
        program_entry(0, 32'd600, 32'hABCD_E000);
        do_start();
        idle(TIMEOUT - 1);
        check_val("s3_not_yet", 32'(timeout), 32'd0);
        tick();
        check_val("s3_timeout", 32'(timeout), 32'd1);
        check_val("s3_pass", 32'(pass), 32'd0);
        check_val("s3_fail", 32'(fail), 32'd0);

        // Repeated and unrelated stores
        do_reset();
        program_default();
        do_start();
        do_store(32'd600, 32'hABCD_E000);
        do_store(32'h100, 32'h1234_5678);
        do_store(32'd600, 32'hABCD_E000);
        do_store(32'h100, 32'h0);
        do_store(32'd600, 32'hABCD_E000);
        check_val("s4_hits", 32'(hit_count), 32'd1);
        check_val("s4_nofail", 32'(fail), 32'd0);
        do_store(32'd604, 32'd4100);
        check_val("s4_pass", 32'(pass), 32'd1);

        // Final good store on the expiry cycle
        do_reset();
        program_default();
        do_start();
        do_store(32'd600, 32'hABCD_E000);
        idle(TIMEOUT - 2);
        do_store(32'd604, 32'd4100);
        check_val("s5_pass", 32'(pass), 32'd1);
        check_val("s5_timeout", 32'(timeout), 32'd0);

        // Bad store on the expiry cycle
        do_reset();
        program_default();
        do_start();
        idle(TIMEOUT - 1);
        do_store(32'd604, 32'h0000_1000);
        check_val("s5b_fail", 32'(fail), 32'd1);
        check_val("s5b_timeout", 32'(timeout), 32'd0);

        // cfg_we during RUN is ignored
        do_reset();
        program_default();
        do_start();
        program_entry(2, 32'h300, 32'h1);
        do_store(32'd600, 32'hABCD_E000);
        do_store(32'd604, 32'd4100);
        check_val("s6_pass", 32'(pass), 32'd1);

        // Reset mid-RUN, then start with an empty table
        do_reset();
        program_default();
        do_start();
        do_store(32'd600, 32'hABCD_E000);
        do_reset();
        check_val("s6_rst_hits", 32'(hit_count), 32'd0);
        check_val("s6_rst_done", 32'(done), 32'd0);
        do_start();
        check_val("s6_empty_pass", 32'(pass), 32'd1);

        // Randomized episodes
        for (int ep = 0; ep < 60; ep++) begin
            do_reset();
            r = $urandom_range(0, 4);
            for (int j = 0; j < r; j++) begin
                a = pool_addr();
                d = ($urandom_range(0, 7) != 0) ? good_data(a) : (good_data(a) ^ 32'h1);
                program_entry($urandom_range(0, 3), a, d);
            end
            do_start();
            for (int c = 0; c < 14; c++) begin
                r = $urandom_range(0, 99);
                if (r < 6) begin
                    a = pool_addr();
                    program_entry($urandom_range(0, 3), a, good_data(a));
                end else if (r < 9) begin
                    do_reset();
                end else if (r < 12) begin
                    do_start();
                end else if (r < 65) begin
                    a = pool_addr();
                    d = ($urandom_range(0, 5) != 0) ? good_data(a) : (good_data(a) ^ 32'h10);
                    do_store(a, d);
                end else if (r < 75) begin
                    do_store(32'h1000 + 32'($urandom_range(0, 15)), $urandom);
                end else begin
                    dataadr   = pool_addr();
                    writedata = $urandom;
                    tick();
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no end expected end");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
